// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - shared types and constants for the sram-like responder
// Contents: access-size encodings, response queue entry type, stall LFSR seed and step.
package sram_like_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One outstanding response: word to return and cycles left before data_ok.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cnt;
  } resp_entry_t;

  // Fibonacci LFSR, taps 16/14/13/11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - in-order response queue with per-entry latency countdown
// Ports:
//   i_clk, i_resetn      clock, synchronous active-low reset (drops all entries)
//   i_push, i_push_entry enqueue one entry (caller guarantees space or a same-cycle pop)
//   i_pop                retire the head (caller guarantees the queue is not empty)
//   o_head, o_head_valid current head entry and whether the queue holds anything
//   o_count              number of valid entries
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_push,
  input  resp_entry_t       i_push_entry,
  input  logic              i_pop,
  output resp_entry_t       o_head,
  output logic              o_head_valid,
  output logic [CNT_W-1:0]  o_count
);

  resp_entry_t      r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QDEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Every slot counts down regardless of validity: stale slots saturate at 0
  // and are overwritten on push, so no per-slot valid bit is needed.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (i_push && (r_wr_ptr == PTR_W'(i))) begin
        r_mem[i] <= i_push_entry;
      end else if (r_mem[i].cnt != 4'd0) begin
        r_mem[i].cnt <= r_mem[i].cnt - 4'd1;
      end
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule

// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - sram-like data memory slave with fixed-latency in-order responses
// Ports:
//   i_clk, i_resetn      clock, synchronous active-low reset
//   i_req, i_wr          request valid, 1 = write
//   i_size               access size (does not affect the access; full word returned)
//   i_wstrb, i_wdata     write byte lanes and lane-replicated write data
//   i_addr               byte address; word index addr[DEPTH_LOG2+1:2], upper bits alias
//   o_addr_ok            request accepted this cycle
//   o_data_ok, o_rdata   one response this cycle; read word, or 0 for writes
// Optional: SRAM_RESP_RAND_STALL_EN adds LFSR-driven addr_ok stalls (~25% of cycles).
module sram_like_resp
  import sram_like_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_accept;
  logic                  w_stall;
  logic                  w_data_ok;
  logic                  w_head_valid;
  logic [CNT_W-1:0]      w_count;
  resp_entry_t           w_head;
  resp_entry_t           w_push_entry;
  logic                  w_unused;

  assign w_idx    = i_addr[DEPTH_LOG2+1:2];
  assign w_unused = ^{i_size == SIZE_B, i_size == SIZE_H, i_size == SIZE_W,
                      i_addr[31:DEPTH_LOG2+2], i_addr[1:0]};

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_lfsr <= LFSR_SEED;
    else           r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Head compare is purely registered state, so data_ok has no input path.
  assign w_data_ok = w_head_valid && (w_head.cnt == 4'd0);

  // A full queue can still accept when the head retires in the same cycle.
  assign w_accept  = i_resetn && i_req && !w_stall && ((w_count < QFULL) || w_data_ok);

  assign o_addr_ok = w_accept;
  assign o_data_ok = w_data_ok;
  assign o_rdata   = w_data_ok ? w_head.data : 32'd0;

  // Reads snapshot the word at accept, so later writes cannot alter them.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.cnt  = 4'(LATENCY - 1);
    w_push_entry.data = i_wr ? 32'd0 : r_mem[w_idx];
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && i_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wstrb[i]) r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  resp_fifo #(.QDEPTH(QDEPTH)) u_resp_fifo (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_push       (w_accept),
    .i_push_entry (w_push_entry),
    .i_pop        (w_data_ok),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

endmodule

// File: tb/tb_sram_like_resp.sv
// tb/tb_sram_like_resp.sv - self-checking bench for sram_like_resp
module tb_sram_like_resp;

  localparam int A_LAT = 2;
  localparam int A_QD  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_a, req_b, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        ok_a, dok_a, ok_b, dok_b;
  logic [31:0] rd_a, rd_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_like_resp #(.DEPTH_LOG2(12), .LATENCY(A_LAT), .QDEPTH(A_QD)) dut_a (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_a), .i_wr(wr), .i_size(size),
    .i_wstrb(wstrb), .i_addr(addr), .i_wdata(wdata),
    .o_addr_ok(ok_a), .o_data_ok(dok_a), .o_rdata(rd_a));

  sram_like_resp #(.DEPTH_LOG2(12), .LATENCY(3), .QDEPTH(2)) dut_b (
    .i_clk(clk), .i_resetn(resetn), .i_req(req_b), .i_wr(wr), .i_size(size),
    .i_wstrb(wstrb), .i_addr(addr), .i_wdata(wdata),
    .o_addr_ok(ok_b), .o_data_ok(dok_b), .o_rdata(rd_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req_a = r; wr = w; wstrb = s; addr = a; wdata = d;
    size = 2'($urandom_range(0, 2));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ok;
    logic        e_dok;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv [21];

  // Reference model state for the randomized run.
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [int];
  logic [15:0] lfsr_m;
  int          cyc;

  function automatic logic [15:0] model_lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  function automatic bit model_stall(input logic [15:0] l);
`ifdef SRAM_RESP_RAND_STALL_EN
    return (l % 4) == 0;
`else
    return (l == 16'h0) && (l != 16'h0);
`endif
  endfunction

  task automatic b_cyc(input string tag, input logic r, input logic [31:0] a,
                       input logic e_ok, input logic e_dok, input logic [31:0] e_rd);
    req_b = r; wr = 1'b0; addr = a; wstrb = 4'h0;
    @(negedge clk);
    chk({tag, " addr_ok"}, 32'(ok_b), 32'(e_ok));
    chk({tag, " data_ok"}, 32'(dok_b), 32'(e_dok));
    chk({tag, " rdata"}, rd_b, e_rd);
    next_cycle();
  endtask

  initial begin
    resetn = 1'b0; req_b = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset addr_ok", 32'(ok_a), 32'd0);
    chk("reset data_ok", 32'(dok_a), 32'd0);
    chk("reset rdata", rd_a, 32'd0);
    chk("reset b data_ok", 32'(dok_b), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

`ifndef SRAM_RESP_RAND_STALL_EN
    // Table: preload, isolated read latency, byte write, aliasing, full queue.
    tv[0]  = '{1, 1, 4'hF, 32'h14,   32'h1122_3344, 1, 0, 32'h0};
    tv[1]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 32'h0};
    tv[2]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'h0};
    tv[3]  = '{1, 0, 4'h0, 32'h14,   32'h0,         1, 0, 32'h0};
    tv[4]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 32'h0};
    tv[5]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'h1122_3344};
    tv[6]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 32'h0};
    tv[7]  = '{1, 1, 4'h4, 32'h16,   32'hAAAA_AAAA, 1, 0, 32'h0};
    tv[8]  = '{1, 0, 4'h0, 32'h14,   32'h0,         1, 0, 32'h0};
    tv[9]  = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'h0};
    tv[10] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'h11AA_3344};
    tv[11] = '{1, 1, 4'hF, 32'h4000, 32'hDEAD_BEEF, 1, 0, 32'h0};
    tv[12] = '{1, 0, 4'h0, 32'h0,    32'h0,         1, 0, 32'h0};
    tv[13] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'h0};
    tv[14] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'hDEAD_BEEF};
    tv[15] = '{1, 0, 4'h0, 32'h0,    32'h0,         1, 0, 32'h0};
    tv[16] = '{1, 0, 4'h0, 32'h0,    32'h0,         1, 0, 32'h0};
    tv[17] = '{1, 0, 4'h0, 32'h0,    32'h0,         1, 1, 32'hDEAD_BEEF};
    tv[18] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'hDEAD_BEEF};
    tv[19] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 1, 32'hDEAD_BEEF};
    tv[20] = '{0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 32'h0};
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].req, tv[i].wr, tv[i].wstrb, tv[i].addr, tv[i].wdata);
      @(negedge clk);
      chk($sformatf("tv%0d addr_ok", i), 32'(ok_a), 32'(tv[i].e_ok));
      chk($sformatf("tv%0d data_ok", i), 32'(dok_a), 32'(tv[i].e_dok));
      chk($sformatf("tv%0d rdata", i), rd_a, tv[i].e_rd);
      next_cycle();
    end

    // Reset one cycle after accepting a read: the response must never appear.
    drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    @(negedge clk);
    chk("rst accept", 32'(ok_a), 32'd1);
    next_cycle();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst addr_ok low", 32'(ok_a), 32'd0);
    chk("rst data_ok low", 32'(dok_a), 32'd0);
    chk("rst rdata low", rd_a, 32'd0);
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst dropped %0d", i), 32'(dok_a), 32'd0);
      next_cycle();
    end
    // Memory survives reset.
    drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("mem after rst data_ok", 32'(dok_a), 32'd1);
    chk("mem after rst rdata", rd_a, 32'h11AA_3344);
    next_cycle();

    // LATENCY=3 / QDEPTH=2 instance: preload words 0..2, then hold req for three reads.
    for (int i = 0; i < 3; i++) begin
      req_b = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'(i * 4); wdata = 32'hB000_0000 + 32'(i);
      next_cycle();
      req_b = 1'b0; wr = 1'b0;
      repeat (4) next_cycle();
    end
    b_cyc("b T",   1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    b_cyc("b T+1", 1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
    b_cyc("b T+2", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    b_cyc("b T+3", 1'b1, 32'h8, 1'b1, 1'b1, 32'hB000_0000);
    b_cyc("b T+4", 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0001);
    b_cyc("b T+5", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    b_cyc("b T+6", 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0002);
    b_cyc("b T+7", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
`endif

    // Randomized traffic against the reference model.
    resetn = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    resetn = 1'b1;
    lfsr_m = 16'hACE1;
    cyc = 0;
    q.delete();
    for (int n = 0; n < 1300; n++) begin
      logic        r, w, e_ok, e_dok;
      logic [3:0]  s;
      logic [31:0] a, d, e_rd;
      int          idx;
      idx = int'($urandom_range(0, 15));
      r = (n < 1280) && ($urandom_range(0, 9) < 7);
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if (!mm.exists(idx)) begin
        w = 1'b1;
        s = 4'hF;
      end
      drive(r, w, s, a, d);
      @(negedge clk);
      e_dok = (q.size() > 0) && (q[0].due == cyc);
      e_ok  = r && ((q.size() < A_QD) || e_dok) && !model_stall(lfsr_m);
      e_rd  = e_dok ? q[0].data : 32'h0;
      chk($sformatf("rnd%0d addr_ok", n), 32'(ok_a), 32'(e_ok));
      chk($sformatf("rnd%0d data_ok", n), 32'(dok_a), 32'(e_dok));
      chk($sformatf("rnd%0d rdata", n), rd_a, e_rd);
      @(posedge clk);
      if (e_dok) void'(q.pop_front());
      if (e_ok) begin
        if (w) begin
          for (int k = 0; k < 4; k++)
            if (s[k]) mm[idx][8*k +: 8] = d[8*k +: 8];
          q.push_back('{32'h0, cyc + A_LAT});
        end else begin
          q.push_back('{mm[idx], cyc + A_LAT});
        end
      end
      lfsr_m = model_lfsr_step(lfsr_m);
      cyc++;
      #1;
    end
    chk("rnd drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
